// File: rtl/uart_tx_fifo_ip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_ip_pkg
// Description : Shared definitions for the buffered UART transmitter:
//               oversampling ratio, parity mode codes, FSM state encoding
//               and the parity helper used when a word is popped.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_ip_pkg;

    // Ticks per bit. The RX IP uses the same ratio.
    localparam int c_OVERSAMPLE = 16;

    localparam logic [1:0] c_PAR_NONE = 2'd0;
    localparam logic [1:0] c_PAR_EVEN = 2'd1;
    localparam logic [1:0] c_PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Narrower words are zero-extended by the caller. Zero-extension leaves
    // the XOR reduction unchanged.
    function automatic logic calc_parity(input logic [1:0] mode, input logic [8:0] data);
        return (mode == c_PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_ip_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_ip_sync_fifo
// Description : Synchronous show-ahead FIFO with registered full/empty/count.
//               A push while full is accepted only when a pop happens in the
//               same cycle. Otherwise the word is dropped and drop_o pulses.
// Ports       : clk_i, rst_i (async active-low), wr_i/din_i push side,
//               rd_i pop request, dout_o head word, full_o, empty_o,
//               count_o occupancy, drop_o combinational drop indication.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_ip_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = rd_i && !r_empty;
    // A full FIFO frees one slot in the same cycle it pops, so that write can land.
    assign w_push = wr_i && (!r_full || w_pop);
    assign drop_o = wr_i && r_full && !w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= din_i;
    end

    assign dout_o  = r_mem[r_rd_ptr];
    assign full_o  = r_full;
    assign empty_o = r_empty;
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_ip.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_ip
// Description : Buffered UART transmitter. Words written via wr_i are queued
//               in a FIFO and serialised autonomously. The baud tick comes
//               from a runtime divisor with 16x oversampling.
// Ports       : clk_i, rst_i (async assert / sync release, active-low)
//               dvsr_i           tick period = dvsr_i+1 clocks
//               wr_i, din_i      push side. full_o, empty_o, count_o status
//               overflow_o       sticky drop flag, cleared by clr_ovf_i
//               tx_o             serial line, idle high, registered
//               busy_o           frame in progress
//               tx_done_tick_o   one-cycle pulse after the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_ip
    import uart_tx_fifo_ip_pkg::*;
#(
    parameter int WORD_LENGTH    = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BIT_TICKS = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int DVSR_WIDTH     = 11
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [DVSR_WIDTH-1:0]           dvsr_i,
    input  logic                            wr_i,
    input  logic [WORD_LENGTH-1:0]          din_i,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o,
    output logic                            overflow_o,
    input  logic                            clr_ovf_i,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic                            tx_done_tick_o
);

    localparam logic [1:0] c_PMODE     = 2'(PARITY_MODE);
    localparam logic [4:0] c_LAST_OS   = 5'(c_OVERSAMPLE - 1);
    localparam logic [4:0] c_LAST_STOP = 5'(STOP_BIT_TICKS - 1);
    localparam logic [3:0] c_LAST_BIT  = 4'(WORD_LENGTH - 1);

    // Reset synchroniser. The reset asserts asynchronously so tx_o returns
    // high at once, and releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // FIFO
    logic [WORD_LENGTH-1:0] w_fifo_dout;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;
    logic                   w_pop;

    uart_tx_fifo_ip_sync_fifo #(
        .WIDTH (WORD_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (w_rst_n),
        .wr_i    (wr_i),
        .din_i   (din_i),
        .rd_i    (w_pop),
        .dout_o  (w_fifo_dout),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (count_o),
        .drop_o  (w_drop)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    logic r_ovf;
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n)       r_ovf <= 1'b0;
        else if (w_drop)    r_ovf <= 1'b1;
        else if (clr_ovf_i) r_ovf <= 1'b0;
    end

    // Baud generator and transmit FSM
    tx_state_t               r_state, w_state_next;
    logic [DVSR_WIDTH-1:0]   r_baud, w_baud_next;
    logic [DVSR_WIDTH-1:0]   r_dvsr;
    logic [4:0]              r_s_cnt, w_s_cnt_next;
    logic [3:0]              r_n_cnt, w_n_cnt_next;
    logic [WORD_LENGTH-1:0]  r_shreg, w_shreg_next;
    logic                    r_par, w_par_next;
    logic                    r_tx, w_tx_next;
    logic                    r_done, w_done_next;
    logic                    w_tick;

    // r_dvsr is captured at frame start. A divisor change mid-frame only
    // affects the next frame.
    assign w_tick = (r_baud == r_dvsr);

    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_n_cnt_next = r_n_cnt;
        w_shreg_next = r_shreg;
        w_par_next   = r_par;
        w_done_next  = 1'b0;
        w_pop        = 1'b0;
        w_baud_next  = (r_state == ST_IDLE || w_tick) ? '0 : r_baud + DVSR_WIDTH'(1);

        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shreg_next = w_fifo_dout;
                    w_par_next   = calc_parity(c_PMODE, 9'(w_fifo_dout));
                    w_s_cnt_next = '0;
                    w_n_cnt_next = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s_cnt == c_LAST_OS) begin
                        w_s_cnt_next = '0;
                        w_state_next = ST_DATA;
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == c_LAST_OS) begin
                        w_s_cnt_next = '0;
                        w_shreg_next = r_shreg >> 1;
                        if (r_n_cnt == c_LAST_BIT) begin
                            w_state_next = (c_PMODE != c_PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            w_n_cnt_next = r_n_cnt + 4'd1;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    if (r_s_cnt == c_LAST_OS) begin
                        w_s_cnt_next = '0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == c_LAST_STOP) begin
                        w_s_cnt_next = '0;
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // The line level follows the next state so that tx_o is a plain
        // flop aligned with the state register.
        unique case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shreg_next[0];
            ST_PARITY: w_tx_next = w_par_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_dvsr  <= '0;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_s_cnt <= w_s_cnt_next;
            r_n_cnt <= w_n_cnt_next;
            r_shreg <= w_shreg_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
            if (w_pop) r_dvsr <= dvsr_i;
        end
    end

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign overflow_o     = r_ovf;
    assign tx_o           = r_tx;
    assign busy_o         = (r_state != ST_IDLE);
    assign tx_done_tick_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_ip.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_ip
// Description : Self-checking bench. The main instance (8N1, depth 16) is
//               followed cycle by cycle by a queue-based line model. Three
//               extra instances (even parity, odd parity, 7 data bits with
//               2 stop bits) are checked against hand-computed frame shapes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_ip;

    localparam int M_WL    = 8;
    localparam int M_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] dvsr;
    logic        wr;
    logic [7:0]  din;
    logic        clr_ovf;
    logic        full, empty, ovf, tx, busy, done;
    logic [4:0]  count;

    logic [2:0]  aux_wr;
    logic [7:0]  aux_din [3];
    logic [2:0]  aux_full, aux_empty, aux_ovf, aux_tx, aux_busy, aux_done;
    logic [4:0]  aux_count [3];

    always #5 clk = ~clk;

    uart_tx_fifo_ip #(.WORD_LENGTH(8), .PARITY_MODE(0), .STOP_BIT_TICKS(16),
                      .FIFO_DEPTH(16), .DVSR_WIDTH(11)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .dvsr_i(dvsr), .wr_i(wr), .din_i(din),
        .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(ovf),
        .clr_ovf_i(clr_ovf), .tx_o(tx), .busy_o(busy), .tx_done_tick_o(done));

    uart_tx_fifo_ip #(.WORD_LENGTH(8), .PARITY_MODE(1), .STOP_BIT_TICKS(16),
                      .FIFO_DEPTH(16), .DVSR_WIDTH(11)) u_even (
        .clk_i(clk), .rst_i(rst_n), .dvsr_i(dvsr), .wr_i(aux_wr[0]), .din_i(aux_din[0]),
        .full_o(aux_full[0]), .empty_o(aux_empty[0]), .count_o(aux_count[0]),
        .overflow_o(aux_ovf[0]), .clr_ovf_i(clr_ovf), .tx_o(aux_tx[0]),
        .busy_o(aux_busy[0]), .tx_done_tick_o(aux_done[0]));

    uart_tx_fifo_ip #(.WORD_LENGTH(8), .PARITY_MODE(2), .STOP_BIT_TICKS(16),
                      .FIFO_DEPTH(16), .DVSR_WIDTH(11)) u_odd (
        .clk_i(clk), .rst_i(rst_n), .dvsr_i(dvsr), .wr_i(aux_wr[1]), .din_i(aux_din[1]),
        .full_o(aux_full[1]), .empty_o(aux_empty[1]), .count_o(aux_count[1]),
        .overflow_o(aux_ovf[1]), .clr_ovf_i(clr_ovf), .tx_o(aux_tx[1]),
        .busy_o(aux_busy[1]), .tx_done_tick_o(aux_done[1]));

    uart_tx_fifo_ip #(.WORD_LENGTH(7), .PARITY_MODE(0), .STOP_BIT_TICKS(32),
                      .FIFO_DEPTH(16), .DVSR_WIDTH(11)) u_7n2 (
        .clk_i(clk), .rst_i(rst_n), .dvsr_i(dvsr), .wr_i(aux_wr[2]), .din_i(aux_din[2][6:0]),
        .full_o(aux_full[2]), .empty_o(aux_empty[2]), .count_o(aux_count[2]),
        .overflow_o(aux_ovf[2]), .clr_ovf_i(clr_ovf), .tx_o(aux_tx[2]),
        .busy_o(aux_busy[2]), .tx_done_tick_o(aux_done[2]));

    logic [3:0] mon_tx, mon_done;
    assign mon_tx   = {tx, aux_tx};
    assign mon_done = {done, aux_done};

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line model for the main instance ----------------
    logic [7:0] mq [$];     // queued words
    bit         wq [$];     // line levels for the cycles of the current frame
    bit e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_ovf = 1'b0, pend = 1'b0;

    // Each bit lasts 16 ticks of (d+1) clocks: start, data LSB first, stop.
    function automatic void add_frame(input logic [7:0] w, input int d);
        int t;
        t = 16 * (d + 1);
        for (int i = 0; i < t; i++) wq.push_back(1'b0);
        for (int b = 0; b < M_WL; b++)
            for (int i = 0; i < t; i++) wq.push_back(w[b]);
        for (int i = 0; i < t; i++) wq.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete(); wq.delete();
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0; pend = 1'b0;
        end else begin : step
            int   pc;
            bit   pop, full_p, push, drop;
            logic [7:0] w;
            pc     = mq.size();
            full_p = (pc == M_DEPTH);
            pop    = !e_busy && (pc > 0);
            push   = wr && (!full_p || pop);
            drop   = wr && full_p && !pop;
            if (pop) begin
                w = mq.pop_front();
                add_frame(w, int'(dvsr));
            end
            if (push) mq.push_back(din);
            if (drop) e_ovf = 1'b1;
            else if (clr_ovf) e_ovf = 1'b0;
            if (wq.size() > 0) begin
                e_tx = wq.pop_front(); e_busy = 1'b1; e_done = 1'b0;
                if (wq.size() == 0) pend = 1'b1;
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_done = pend; pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                chk("rst_tx", 32'(tx), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_empty", 32'(empty), 32'd1);
                chk("rst_full", 32'(full), 32'd0);
                chk("rst_count", 32'(count), 32'd0);
                chk("rst_ovf", 32'(ovf), 32'd0);
            end else begin
                chk("tx", 32'(tx), 32'(e_tx));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("done", 32'(done), 32'(e_done));
                chk("count", 32'(count), 32'(mq.size()));
                chk("empty", 32'(empty), 32'(mq.size() == 0));
                chk("full", 32'(full), 32'(mq.size() == M_DEPTH));
                chk("ovf", 32'(ovf), 32'(e_ovf));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic cap [0:1023];

    task automatic send(input int which, input logic [7:0] d);
        @(posedge clk); #1;
        if (which == 3) begin wr = 1'b1; din = d; end
        else begin aux_wr[which] = 1'b1; aux_din[which] = d; end
        @(posedge clk); #1;
        wr = 1'b0; aux_wr = '0;
    endtask

    // Records line levels from the first low cycle; len = index of the done pulse.
    task automatic capture(input int which, output int len);
        int n;
        bit started;
        n = 0; started = 1'b0; len = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!started && mon_tx[which] == 1'b0) started = 1'b1;
            if (started) begin
                if (mon_done[which]) begin len = n; break; end
                if (n < 1024) cap[n] = mon_tx[which];
                n++;
            end
        end
        if (len < 0) chk("capture_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (empty && !busy) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    int len;
    int t1_exp [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        rst_n = 1'b0; dvsr = 11'd1; wr = 1'b0; din = '0; clr_ovf = 1'b0;
        aux_wr = '0;
        for (int i = 0; i < 3; i++) aux_din[i] = '0;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 8N1, 0x55 at dvsr=1: 32 clocks per bit, done 320 clocks after start
        send(3, 8'h55);
        capture(3, len);
        chk("t1_frame_len", 32'(len), 32'd320);
        chk("t1_start_first", 32'(cap[0]), 32'd0);
        chk("t1_start_last", 32'(cap[31]), 32'd0);
        for (int b = 0; b < 10; b++) chk("t1_bit", 32'(cap[b*32+16]), 32'(t1_exp[b]));
        wait_idle(100);

        // dvsr=0 frame, then a divisor change that only the queued frame sees
        dvsr = 11'd0;
        send(3, 8'hA3);
        send(3, 8'h5C);
        dvsr = 11'd2;
        wait_idle(2000);
        dvsr = 11'd1;

        // Burst of 17 while a frame is running: 16 accepted, 17th dropped
        send(3, 8'h81);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            wr = 1'b1; din = 8'(8'h10 + i);
        end
        @(posedge clk); #1;
        wr = 1'b0;
        chk("burst_count", 32'(count), 32'd16);
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_ovf", 32'(ovf), 32'd1);
        // drop and clear in the same cycle: the drop wins
        wr = 1'b1; din = 8'hF0; clr_ovf = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; clr_ovf = 1'b0;
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // Write while full in the cycle of a pop: accepted, count stays 16
        begin : wait_pop
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                if (done) begin seen = 1'b1; break; end
            end
            if (!seen) chk("pop_wait_timeout", 32'd0, 32'd1);
        end
        wr = 1'b1; din = 8'hEE;
        @(posedge clk); #1;
        wr = 1'b0;
        chk("pushpop_count", 32'(count), 32'd16);
        chk("pushpop_full", 32'(full), 32'd1);
        chk("pushpop_ovf", 32'(ovf), 32'd0);
        wait_idle(8000);

        // Reset in the middle of the data bits
        send(3, 8'hC3);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        send(3, 8'h3C);
        capture(3, len);
        chk("after_rst_len", 32'(len), 32'd320);
        chk("after_rst_bit2", 32'(cap[3*32+16]), 32'd1);
        wait_idle(100);

        // Parity instances: 0x07 has three ones, frame is 352 clocks
        send(0, 8'h07);
        capture(0, len);
        chk("even_len", 32'(len), 32'd352);
        chk("even_parity", 32'(cap[9*32+16]), 32'd1);
        send(1, 8'h07);
        capture(1, len);
        chk("odd_len", 32'(len), 32'd352);
        chk("odd_parity", 32'(cap[9*32+16]), 32'd0);

        // 7 data bits, 2 stop bits: stop high 64 clocks, frame 320 clocks
        send(2, 8'h3F);
        capture(2, len);
        chk("7n2_len", 32'(len), 32'd320);
        chk("7n2_last_data", 32'(cap[255]), 32'd0);
        chk("7n2_stop_first", 32'(cap[256]), 32'd1);
        chk("7n2_stop_last", 32'(cap[319]), 32'd1);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
